// File: rtl/workload_rr_dispatcher_if.sv
// Handshake bundle between workload sources, the round-robin dispatcher and the pipeline link.
// The dispatcher side uses the slave modport; the master modport is for whatever drives it.
interface workload_rr_dispatcher_if #(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned id_width_p     = 8,
    parameter int unsigned size_width_p   = 8,
    parameter int unsigned max_inflight_p = 4
);
    localparam int unsigned width_p = id_width_p + size_width_p;
    localparam int unsigned cw_lp   = $clog2(max_inflight_p + 1);
    localparam int unsigned sw_lp   = $clog2(num_req_p);

    logic [num_req_p-1:0]         v_i;
    logic [num_req_p*width_p-1:0] data_i;
    logic [num_req_p-1:0]         ready_o;
    logic                         v_o;
    logic [width_p-1:0]           data_o;
    logic [sw_lp-1:0]             src_o;
    logic                         ready_i;
    logic                         done_v_i;
    logic [cw_lp-1:0]             credits_o;
    logic                         err_o;

    modport slave (
        input  v_i, data_i, ready_i, done_v_i,
        output ready_o, v_o, data_o, src_o, credits_o, err_o
    );

    modport master (
        output v_i, data_i, ready_i, done_v_i,
        input  ready_o, v_o, data_o, src_o, credits_o, err_o
    );
endinterface

// File: rtl/workload_rr_dispatcher.sv
// Round-robin dispatcher sharing one pipeline input link among workload sources.
// A registered output slot feeds the pipeline; a credit counter bounds in-flight workloads.
module workload_rr_dispatcher #(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned id_width_p     = 8,
    parameter int unsigned size_width_p   = 8,
    parameter int unsigned max_inflight_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    workload_rr_dispatcher_if.slave  bus
);
    localparam int unsigned width_p = id_width_p + size_width_p;
    localparam int unsigned cw_lp   = $clog2(max_inflight_p + 1);
    localparam int unsigned sw_lp   = $clog2(num_req_p);

    localparam logic [cw_lp-1:0] max_credits_lp = cw_lp'(max_inflight_p);
    localparam logic [sw_lp-1:0] last_rst_lp    = sw_lp'(num_req_p - 1);

    logic                 v_q;
    logic [width_p-1:0]   data_q;
    logic [sw_lp-1:0]     src_q;
    logic [sw_lp-1:0]     last_q;
    logic [cw_lp-1:0]     credits_q;
    logic                 err_q;

    logic                 slot_free;
    logic                 grant_en;
    logic                 found;
    logic                 accept;
    logic [sw_lp-1:0]     winner;
    logic [sw_lp-1:0]     cand;
    logic [num_req_p-1:0] ready_c;
    logic [width_p-1:0]   winner_data;

    assign slot_free = !v_q || bus.ready_i;
    assign grant_en  = slot_free && (credits_q != '0);

    // First valid requester after last_q, wrapping; idle requesters cost nothing.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand = sw_lp'((32'(last_q) + i) % num_req_p);
            if (!found && bus.v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept      = grant_en && found;
    assign winner_data = bus.data_i[32'(winner)*width_p +: width_p];

    always_comb begin
        ready_c = '0;
        if (accept) begin
            ready_c[winner] = 1'b1;
        end
    end

    // Output slot: load on accept, drop valid when consumed with nothing new behind it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            last_q <= last_rst_lp;
        end else if (accept) begin
            v_q    <= 1'b1;
            data_q <= winner_data;
            src_q  <= winner;
            last_q <= winner;
        end else if (v_q && bus.ready_i) begin
            v_q <= 1'b0;
        end
    end

    // Credits: accept consumes, completion returns; a return at full credit is an overflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q <= max_credits_lp;
            err_q     <= 1'b0;
        end else begin
            case ({accept, bus.done_v_i})
                2'b10: credits_q <= credits_q - cw_lp'(1);
                2'b01: begin
                    if (credits_q == max_credits_lp) begin
                        err_q <= 1'b1;
                    end else begin
                        credits_q <= credits_q + cw_lp'(1);
                    end
                end
                default: credits_q <= credits_q;
            endcase
        end
    end

    assign bus.ready_o   = ready_c;
    assign bus.v_o       = v_q;
    assign bus.data_o    = data_q;
    assign bus.src_o     = src_q;
    assign bus.credits_o = credits_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_workload_rr_dispatcher.sv
// Directed bench for workload_rr_dispatcher with hand-computed expectations.
module tb_workload_rr_dispatcher;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   acc;

    workload_rr_dispatcher_if #(
        .num_req_p(2), .id_width_p(8), .size_width_p(8), .max_inflight_p(4)
    ) bus ();

    workload_rr_dispatcher #(
        .num_req_p(2), .id_width_p(8), .size_width_p(8), .max_inflight_p(4)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tok(input int k, input logic [15:0] t);
        bus.data_i[k*16 +: 16] = t;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        acc          = 0;
        rst_n        = 1'b0;
        bus.v_i      = '0;
        bus.data_i   = '0;
        bus.ready_i  = 1'b0;
        bus.done_v_i = 1'b0;

        // Reset values
        tick(); tick();
        chk("rst_v_o",     32'(bus.v_o),       32'h0);
        chk("rst_data_o",  32'(bus.data_o),    32'h0);
        chk("rst_src_o",   32'(bus.src_o),     32'h0);
        chk("rst_credits", 32'(bus.credits_o), 32'd4);
        chk("rst_err",     32'(bus.err_o),     32'h0);
        chk("rst_ready",   32'(bus.ready_o),   32'h0);

        // Release with only requester 1 valid
        rst_n       = 1'b1;
        bus.v_i     = 2'b10;
        set_tok(1, 16'h0305);
        bus.ready_i = 1'b1;
        #1;
        chk("first_ready", 32'(bus.ready_o), 32'b10);
        tick();
        chk("first_data",    32'(bus.data_o),    32'h0305);
        chk("first_src",     32'(bus.src_o),     32'd1);
        chk("first_v",       32'(bus.v_o),       32'd1);
        chk("first_credits", 32'(bus.credits_o), 32'd3);

        // Round robin with a completion every cycle
        bus.v_i      = 2'b11;
        bus.done_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_tok(0, 16'h1000 + 16'(i));
            set_tok(1, 16'h2000 + 16'(i));
            #1;
            chk("rr_ready", 32'(bus.ready_o), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
            chk("rr_src",     32'(bus.src_o),     32'(i % 2));
            chk("rr_data",    32'(bus.data_o),    (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
            chk("rr_credits", 32'(bus.credits_o), 32'd3);
        end

        // Refill to full, then exhaust credits
        bus.v_i = 2'b00;
        tick();
        chk("refill_credits", 32'(bus.credits_o), 32'd4);
        bus.done_v_i = 1'b0;
        bus.v_i      = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.ready_o != '0) acc++;
            tick();
        end
        chk("exh_accepts", 32'(acc),           32'd4);
        chk("exh_credits", 32'(bus.credits_o), 32'd0);
        chk("exh_ready",   32'(bus.ready_o),   32'd0);
        chk("exh_v_o",     32'(bus.v_o),       32'd0);
        bus.done_v_i = 1'b1;
        #1;
        chk("exh_ready_done_cycle", 32'(bus.ready_o), 32'd0);
        tick();
        bus.done_v_i = 1'b0;
        chk("exh_credit_back", 32'(bus.credits_o), 32'd1);
        set_tok(0, 16'hA0A0);
        #1;
        chk("exh_one_more_ready", 32'(bus.ready_o), 32'b01);
        tick();
        chk("exh_one_more_src",  32'(bus.src_o),     32'd0);
        chk("exh_one_more_data", 32'(bus.data_o),    32'hA0A0);
        chk("exh_credits_again", 32'(bus.credits_o), 32'd0);
        chk("exh_ready_after",   32'(bus.ready_o),   32'd0);

        // Backpressure: five stalled cycles, two completions along the way
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.done_v_i = (i < 2);
            set_tok(0, 16'h5500 + 16'(i));
            #1;
            chk("bp_ready", 32'(bus.ready_o), 32'd0);
            tick();
            chk("bp_data", 32'(bus.data_o), 32'hA0A0);
            chk("bp_src",  32'(bus.src_o),  32'd0);
            chk("bp_v",    32'(bus.v_o),    32'd1);
        end
        chk("bp_credits", 32'(bus.credits_o), 32'd2);

        // Release backpressure: grant in the same cycle, with a simultaneous completion
        bus.ready_i  = 1'b1;
        bus.done_v_i = 1'b1;
        set_tok(1, 16'h7777);
        #1;
        chk("bp_release_ready", 32'(bus.ready_o), 32'b10);
        tick();
        chk("sim_credits", 32'(bus.credits_o), 32'd2);
        chk("sim_src",     32'(bus.src_o),     32'd1);
        chk("sim_data",    32'(bus.data_o),    32'h7777);

        // Overflow: completions with no accepts until above full
        bus.v_i = 2'b00;
        tick();
        chk("ovf_c3", 32'(bus.credits_o), 32'd3);
        tick();
        chk("ovf_c4", 32'(bus.credits_o), 32'd4);
        chk("ovf_err_clear", 32'(bus.err_o), 32'd0);
        tick();
        bus.done_v_i = 1'b0;
        chk("ovf_c_sat", 32'(bus.credits_o), 32'd4);
        chk("ovf_err",   32'(bus.err_o),     32'd1);
        tick(); tick();
        chk("ovf_err_sticky", 32'(bus.err_o), 32'd1);

        // Build up credits=1 with a token held in the slot
        bus.v_i = 2'b01;
        set_tok(0, 16'hBEEF);
        tick(); tick(); tick();
        bus.v_i     = 2'b00;
        bus.ready_i = 1'b0;
        chk("pre_rst_credits", 32'(bus.credits_o), 32'd1);
        chk("pre_rst_v",       32'(bus.v_o),       32'd1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_v",       32'(bus.v_o),       32'd0);
        chk("arst_data",    32'(bus.data_o),    32'd0);
        chk("arst_src",     32'(bus.src_o),     32'd0);
        chk("arst_credits", 32'(bus.credits_o), 32'd4);
        chk("arst_err",     32'(bus.err_o),     32'd0);
        tick();
        rst_n       = 1'b1;
        bus.v_i     = 2'b11;
        bus.ready_i = 1'b1;
        set_tok(0, 16'h0101);
        set_tok(1, 16'h0202);
        #1;
        chk("post_rst_ready", 32'(bus.ready_o), 32'b01);
        tick();
        chk("post_rst_src",  32'(bus.src_o),  32'd0);
        chk("post_rst_data", 32'(bus.data_o), 32'h0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
